// File: rtl/wallace_mul_sched.sv
// wallace_mul_sched: credit-gated round-robin scheduler that shares one fixed-latency multiplier
// among NREQ requesters. Define WALLACE_SCHED_PRIO0_EN to give requester 0 fixed top priority.
module wallace_mul_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W-1:0]      req_a,
  input  logic [NREQ*W-1:0]      req_b,
  output logic                   mul_valid,
  output logic [W-1:0]           mul_a,
  output logic [W-1:0]           mul_b,
  input  logic [2*W-1:0]         mul_p,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*2*W-1:0]    rsp_p
);
  localparam int TW = $clog2(NREQ);
  localparam int PW = 2 * W;

  logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0][TW-1:0] pipe_tag_q, pipe_tag_d;
  logic [TW-1:0]          last_q, last_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NREQ*PW-1:0]     rsp_p_q, rsp_p_d;

  logic [NREQ-1:0] in_flight;
  logic [NREQ-1:0] credit;
  logic [NREQ-1:0] eligible;
  logic            grant;
  logic [TW-1:0]   grant_idx;
  logic [TW-1:0]   cand;
  logic            cap_en;
  logic [TW-1:0]   cap_tag;

  // NOTE: every always_comb output is given a default before any branch, so no path can infer a latch.
  always_comb begin
    in_flight = '0;
    for (int s = 0; s < LAT; s++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pipe_vld_q[s] && pipe_tag_q[s] == TW'(i)) in_flight[i] = 1'b1;
      end
    end
  end

  // A requester may hold only one operation, from issue until its result is accepted.
  assign credit   = ~in_flight & ~rsp_valid_q;
  assign eligible = rst_n ? (req_valid & credit) : '0;

`ifdef WALLACE_SCHED_PRIO0_EN
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (eligible[0]) begin
      grant = 1'b1;
    end else begin
      // Round-robin over 1..NREQ-1 only; last_q never holds 0 in this mode.
      for (int k = 1; k < NREQ; k++) begin
        cand = TW'(((int'(last_q) - 1 + k) % (NREQ - 1)) + 1);
        if (!grant && eligible[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign last_d = (grant && grant_idx != '0) ? grant_idx : last_q;
`else
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = TW'((int'(last_q) + k) % NREQ);
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign last_d = grant ? grant_idx : last_q;
`endif

  always_comb begin
    req_ready = '0;
    mul_valid = grant;
    mul_a     = '0;
    mul_b     = '0;
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
      mul_a = req_a[int'(grant_idx)*W +: W];
      mul_b = req_b[int'(grant_idx)*W +: W];
    end
  end

  assign cap_en  = pipe_vld_q[LAT-1];
  assign cap_tag = pipe_tag_q[LAT-1];

  always_comb begin
    pipe_vld_d[0] = grant;
    pipe_tag_d[0] = grant_idx;
    for (int s = 1; s < LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_tag_d[s] = pipe_tag_q[s-1];
    end
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) rsp_valid_d[i] = 1'b0;
      if (cap_en && cap_tag == TW'(i)) begin
        rsp_valid_d[i]         = 1'b1;
        rsp_p_d[i*PW +: PW]    = mul_p;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_tag_q  <= '0;
      last_q      <= TW'(NREQ - 1);
      rsp_valid_q <= '0;
      // NOTE: result registers are architecturally visible, so they are reset, not left undefined.
      rsp_p_q     <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_tag_q  <= pipe_tag_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;

  // Credit gating makes a capture and an accept for the same requester impossible.
  a_no_cap_accept_clash: assert property (@(posedge clk) disable iff (!rst_n)
    !(cap_en && rsp_valid_q[cap_tag] && rsp_ready[cap_tag]));

endmodule

// File: tb/tb_wallace_mul_sched.sv
// tb_wallace_mul_sched: scoreboard bench with a behavioural signed multiplier of latency LAT and a
// credit/round-robin reference model; directed phases followed by randomized traffic.
module tb_wallace_mul_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 3;
  localparam int PW   = 2 * W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0]    req_a, req_b;
  logic                 mul_valid;
  logic [W-1:0]         mul_a, mul_b;
  logic [PW-1:0]        mul_p;
  logic [NREQ*PW-1:0]   rsp_p;

  wallace_mul_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  exp_t          exp_q [NREQ][$];
  bit            busy [NREQ];
  bit            took [NREQ];
  logic [PW-1:0] last_acc [NREQ];
  int            last_all, last_rr;
  int            grant_log [$];
  logic [PW-1:0] msr [LAT];
  logic [PW-1:0] pend_p;

  bit            en [NREQ];
  int            rate, rdy_pct, drop_pct;
  bit            fixed_ops;
  logic [W-1:0]  fa [NREQ], fb [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Expected winner among eligible requesters, searching in order after the previous winner.
  function automatic int model_pick(input logic [NREQ-1:0] elig);
    int c;
`ifdef WALLACE_SCHED_PRIO0_EN
    if (elig[0]) return 0;
    for (int k = 1; k < NREQ; k++) begin
      c = last_rr + k;
      if (c >= NREQ) c -= NREQ - 1;
      if (elig[c]) return c;
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      c = (last_all + k) % NREQ;
      if (elig[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      busy[i] = 1'b0;
      took[i] = 1'b0;
      exp_q[i].delete();
    end
    last_all = NREQ - 1;
    last_rr  = NREQ - 1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural multiplier: operands seen in cycle t return as mul_p in cycle t+LAT.
  initial begin
    for (int k = 0; k < LAT; k++) msr[k] = '0;
    mul_p = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = LAT - 1; k > 0; k--) msr[k] = msr[k-1];
      msr[0] = pend_p;
      mul_p  = msr[LAT-1];
    end
  end

  // Issue monitor: predicts the grant, checks the issue port, pushes the expected result.
  initial begin
    logic [NREQ-1:0] elig;
    int              g;
    forever begin
      @(negedge clk);
      pend_p = mul_valid ? smul(mul_a, mul_b) : PW'($urandom);
      if (rst_n) begin
        for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && !busy[i];
        g = model_pick(elig);
        check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        check("mul_valid", 64'(mul_valid), (g < 0) ? 64'd0 : 64'd1);
        if (g >= 0) begin
          check("mul_a", 64'(mul_a), 64'(req_a[g*W +: W]));
          check("mul_b", 64'(mul_b), 64'(req_b[g*W +: W]));
          exp_q[g].push_back('{prod: smul(req_a[g*W +: W], req_b[g*W +: W]), cyc: cyc});
          busy[g] = 1'b1;
          took[g] = 1'b1;
          grant_log.push_back(g);
`ifdef WALLACE_SCHED_PRIO0_EN
          if (g != 0) last_rr = g;
`else
          last_all = g;
`endif
        end else begin
          check("mul_ops_idle", {mul_a, mul_b}, 64'd0);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each accepted result.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("rsp_idle[%0d]", i), 64'(rsp_valid[i]), 64'd0);
        end else if (cyc < exp_q[i][0].cyc + LAT + 1) begin
          check($sformatf("rsp_early[%0d]", i), 64'(rsp_valid[i]), 64'd0);
        end else begin
          check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd1);
          if (rsp_valid[i]) begin
            check($sformatf("rsp_p[%0d]", i), 64'(rsp_p[i*PW +: PW]), 64'(exp_q[i][0].prod));
            if (rsp_ready[i]) begin
              last_acc[i] = rsp_p[i*PW +: PW];
              void'(exp_q[i].pop_front());
              busy[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (took[i]) begin
        took[i] = 1'b0;
        req_valid[i] = 1'b0;
      end else if (req_valid[i] && $urandom_range(0, 99) < drop_pct) begin
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && en[i] && $urandom_range(0, 99) < rate) begin
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = fixed_ops ? fa[i] : W'($urandom);
        req_b[i*W +: W] = fixed_ops ? fb[i] : W'($urandom);
      end
      rsp_ready[i] = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic setup(input bit e0, input bit e1, input bit e2, input bit e3,
                       input int r, input int rdy, input int drop, input bit fix);
    en = '{e0, e1, e2, e3};
    rate = r; rdy_pct = rdy; drop_pct = drop; fixed_ops = fix;
  endtask

  task automatic drain();
    setup(0, 0, 0, 0, 0, 100, 100, fixed_ops);
    ticks(15);
  endtask

  initial begin
    int mark, n2;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) last_acc[i] = '0;
    setup(0, 0, 0, 0, 0, 100, 0, 0);
    model_reset();

    // Reset state, with requests pending to show the arbiter stays quiet in reset.
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_mul_valid", 64'(mul_valid), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_p", rsp_p, 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four requesting together: grants 0,1,2,3 in consecutive cycles, products 6,10,14,18.
    fa = '{8'd3, 8'd5, 8'd7, 8'd9};
    fb = '{8'd2, 8'd2, 8'd2, 8'd2};
    mark = grant_log.size();
    setup(1, 1, 1, 1, 100, 100, 0, 1);
    ticks(12);
    drain();
    for (int k = 0; k < 4; k++) check($sformatf("p1_grant_order[%0d]", k), 64'(grant_log[mark+k]), 64'(k));
    check("p1_rsp0", 64'(last_acc[0]), 64'd6);
    check("p1_rsp1", 64'(last_acc[1]), 64'd10);
    check("p1_rsp2", 64'(last_acc[2]), 64'd14);
    check("p1_rsp3", 64'(last_acc[3]), 64'd18);

    // Requester 2 alone with its result held for 10 cycles: exactly one grant in that window.
    mark = grant_log.size();
    setup(0, 0, 1, 0, 100, 0, 0, 0);
    ticks(10);
    n2 = 0;
    for (int k = mark; k < grant_log.size(); k++) if (grant_log[k] == 2) n2++;
    check("p2_single_grant", 64'(n2), 64'd1);
    rdy_pct = 100;
    ticks(8);
    drain();

    // Signed corner operands routed to requesters 1 and 3.
    fa[1] = 8'h80; fb[1] = 8'h80;
    fa[3] = 8'hFF; fb[3] = 8'h01;
    setup(0, 1, 0, 1, 100, 100, 0, 1);
    ticks(12);
    drain();
    check("p3_rsp1_signed", 64'(last_acc[1]), 64'h4000);
    check("p3_rsp3_signed", 64'(last_acc[3]), 64'hFFFF);

    // Requesters 0 and 3 continuously valid: grants alternate between them.
    mark = grant_log.size();
    setup(1, 0, 0, 1, 100, 100, 0, 0);
    ticks(30);
    for (int k = mark; k + 1 < grant_log.size(); k++)
      check("p5_alternate", 64'(grant_log[k] != grant_log[k+1]), 64'd1);
    drain();

    // Reset with one result held and three operations in flight.
    setup(1, 1, 1, 1, 100, 0, 0, 0);
    ticks(5);
    @(negedge clk);
    #2;
    check("pre_reset_rsp_held", 64'(rsp_valid != '0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mul_valid", 64'(mul_valid), 64'd0);
    check("rst_rsp_p", rsp_p, 64'd0);
    req_valid = '0;
    setup(0, 0, 0, 0, 0, 100, 0, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(8);

    // Randomized traffic with random back-pressure and withdrawn requests.
    for (int seg = 0; seg < 15; seg++) begin
      setup(1, 1, 1, 1, $urandom_range(20, 100), $urandom_range(30, 100), $urandom_range(0, 20), 0);
      ticks(100);
    end
    drain();

    for (int i = 0; i < NREQ; i++) check($sformatf("scoreboard_empty[%0d]", i), 64'(exp_q[i].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
